// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache rd/wr bus, backed by an internal word RAM with fixed latencies.
// Define RESP_RANDOM_STALL_EN to add LFSR-driven handshake and return-beat stalls.

module cache_mem_responder #(
    parameter int MEM_ADDR_W    = 12,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy
);

    localparam int DEPTH = 1 << MEM_ADDR_W;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_BURST = 2'd2,
        WR_BUSY  = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [MEM_ADDR_W-1:0] addr_r;
    logic [MEM_ADDR_W-1:0] addr_nxt_s;
    logic [2:0]            beats_r;
    logic [2:0]            beats_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [31:0]           mem [DEPTH];

    logic                  rd_fire_s;
    logic                  wr_fire_s;
    logic                  rd_line_s;
    logic                  wr_line_s;
    logic [MEM_ADDR_W-1:0] rd_word_s;
    logic [MEM_ADDR_W-1:0] wr_word_s;
    logic                  stall_s;
    logic                  stall_nxt_s;
    logic                  hold_s;
    logic                  unused_addr_bits_s;

    assign unused_addr_bits_s = ^{rd_addr[31:MEM_ADDR_W+2], rd_addr[1:0],
                                  wr_addr[31:MEM_ADDR_W+2], wr_addr[1:0]};

    assign rd_line_s = (rd_type == 3'b100);
    assign wr_line_s = (wr_type == 3'b100);
    assign rd_word_s = rd_line_s ? {rd_addr[MEM_ADDR_W+1:4], 2'b00} : rd_addr[MEM_ADDR_W+1:2];
    assign wr_word_s = wr_line_s ? {wr_addr[MEM_ADDR_W+1:4], 2'b00} : wr_addr[MEM_ADDR_W+1:2];

`ifdef RESP_RANDOM_STALL_EN
    logic [15:0] lfsr_r;
    logic [15:0] lfsr_nxt_s;

    // Fibonacci LFSR, taps 16,14,13,11
    always_comb begin
        lfsr_nxt_s = {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end

    // LFSR state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= lfsr_nxt_s;
        end
    end

    assign stall_s     = lfsr_r[0];
    assign stall_nxt_s = lfsr_nxt_s[0];
    assign hold_s      = lfsr_r[1];
`else
    assign stall_s     = 1'b0;
    assign stall_nxt_s = 1'b0;
    assign hold_s      = 1'b0;
`endif

    // Handshake ready: writes win over reads, nothing accepted during reset
    always_comb begin
        rd_rdy = 1'b0;
        wr_rdy = 1'b0;
        if (!rst && (state_r == IDLE) && !hold_s) begin
            wr_rdy = 1'b1;
            rd_rdy = !wr_req;
        end else begin
            wr_rdy = 1'b0;
            rd_rdy = 1'b0;
        end
    end

    assign rd_fire_s = rd_req & rd_rdy;
    assign wr_fire_s = wr_req & wr_rdy;

    // Next-state, burst address/beat and latency counter logic
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        beats_nxt_s = beats_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (wr_fire_s) begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                    if (WRITE_LATENCY > 0) begin
                        state_nxt_s = WR_BUSY;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (rd_fire_s) begin
                    addr_nxt_s  = rd_word_s;
                    beats_nxt_s = rd_line_s ? 3'd4 : 3'd1;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    if (READ_LATENCY == 1) begin
                        state_nxt_s = RD_BURST;
                    end else begin
                        state_nxt_s = RD_WAIT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_WAIT: begin
                if (cnt_r == CNT_W'(READ_LATENCY - 2)) begin
                    state_nxt_s = RD_BURST;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            RD_BURST: begin
                if (stall_s) begin
                    state_nxt_s = RD_BURST;
                end else if (beats_r == 3'd1) begin
                    state_nxt_s = IDLE;
                    beats_nxt_s = 3'd0;
                end else begin
                    addr_nxt_s  = addr_r + MEM_ADDR_W'(1);
                    beats_nxt_s = beats_r - 3'd1;
                end
            end
            WR_BUSY: begin
                if (cnt_r == CNT_W'(WRITE_LATENCY - 1)) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            addr_r  <= {MEM_ADDR_W{1'b0}};
            beats_r <= 3'd0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            addr_r  <= addr_nxt_s;
            beats_r <= beats_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Return beat registers, loaded one edge ahead of the cycle they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ret_valid <= 1'b0;
            ret_last  <= 1'b0;
            ret_data  <= 32'h0000_0000;
        end else if ((state_nxt_s == RD_BURST) && !stall_nxt_s) begin
            ret_valid <= 1'b1;
            ret_last  <= (beats_nxt_s == 3'd1);
            ret_data  <= mem[addr_nxt_s];
        end else begin
            ret_valid <= 1'b0;
            ret_last  <= 1'b0;
            ret_data  <= 32'h0000_0000;
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            if (wr_line_s) begin
                for (int i = 0; i < 4; i++) begin
                    mem[{wr_word_s[MEM_ADDR_W-1:2], 2'(i)}] <= wr_data[32*i +: 32];
                end
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_wstrb[b]) begin
                        mem[wr_word_s][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder: scoreboard of expected return beats plus handshake checks.

module tb_cache_mem_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rd_req = 1'b0;
    logic [2:0]   rd_type = 3'b010;
    logic [31:0]  rd_addr = 32'h0;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req = 1'b0;
    logic [2:0]   wr_type = 3'b010;
    logic [31:0]  wr_addr = 32'h0;
    logic [3:0]   wr_wstrb = 4'h0;
    logic [127:0] wr_data = 128'h0;
    logic         wr_rdy;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [0:4095];
    logic [32:0] sb_q [$];

    cache_mem_responder dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy)
    );

    always #5 clk = ~clk;

    task automatic model_write(input logic [31:0] a, input logic [2:0] t,
                               input logic [3:0] s, input logic [127:0] d);
        if (t == 3'b100) begin
            for (int i = 0; i < 4; i++) model[int'(a[13:4]) * 4 + i] = d[32*i +: 32];
        end else begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model[int'(a[13:2])][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic push_read(input logic [31:0] a, input logic [2:0] t);
        if (t == 3'b100) begin
            for (int i = 0; i < 4; i++)
                sb_q.push_back({(i == 3), model[int'(a[13:4]) * 4 + i]});
        end else begin
            sb_q.push_back({1'b1, model[int'(a[13:2])]});
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_write(input logic [31:0] a, input logic [2:0] t, input logic [3:0] s,
                            input logic [127:0] d, input bit also_rd);
        wr_req = 1'b1; wr_addr = a; wr_type = t; wr_wstrb = s; wr_data = d;
        if (also_rd) begin
            rd_req = 1'b1; rd_addr = a; rd_type = 3'b010;
        end
        @(negedge clk);
        checks++;
        if (wr_rdy !== 1'b1) begin
            errors++; $display("FAIL wr_accept: wr_rdy=%b expected 1", wr_rdy);
        end
        if (also_rd) begin
            checks++;
            if (rd_rdy !== 1'b0) begin
                errors++; $display("FAIL wr_priority: rd_rdy=%b expected 0", rd_rdy);
            end
        end
        model_write(a, t, s, d);
        @(posedge clk); #1;
        wr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_rdy !== 1'b0 || rd_rdy !== 1'b0) begin
            errors++; $display("FAIL wr_busy: wr_rdy=%b rd_rdy=%b expected 0 0", wr_rdy, rd_rdy);
        end
        @(posedge clk); #1;
    endtask

    // Raises rd_req, waits for the handshake, pushes expected beats; returns just after the accept edge.
    task automatic issue_read(input logic [31:0] a, input logic [2:0] t, output int waits);
        bit ok;
        ok = 1'b0;
        waits = 0;
        rd_req = 1'b1; rd_addr = a; rd_type = t;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rd_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rd_accept_timeout: rd_rdy never high for addr %h", a);
        end else begin
            push_read(a, t);
        end
        @(posedge clk); #1;
    endtask

    // Scoreboard consumer: watches a window after the accept edge, rd_req held for 'hold' cycles.
    task automatic collect(input int nbeats, input int hold);
        int got;
        logic [32:0] e;
        got = 0;
        for (int k = 1; k <= nbeats + 6; k++) begin
            rd_req = (k <= hold);
            @(negedge clk);
            if (rd_req && rd_rdy) begin
                checks++; errors++;
                $display("FAIL dup_accept: rd_rdy=1 while read in flight, cycle %0d", k);
            end
            if (ret_valid === 1'b1) begin
                got++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++; $display("FAIL stray_beat: data %h at cycle %0d, none expected", ret_data, k);
                end else begin
                    e = sb_q.pop_front();
                    if (ret_data !== e[31:0] || ret_last !== e[32]) begin
                        errors++;
                        $display("FAIL beat_data: got %h last %b expected %h last %b", ret_data, ret_last, e[31:0], e[32]);
                    end
                end
                if (got == 1) begin
                    checks++;
                    if (k != 2) begin
                        errors++; $display("FAIL read_latency: first beat at c0+%0d expected c0+2", k);
                    end
                end else begin
                    checks++;
                    if (k != got + 1) begin
                        errors++; $display("FAIL burst_gap: beat %0d at c0+%0d expected c0+%0d", got, k, got + 1);
                    end
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (got != nbeats || sb_q.size() != 0) begin
            errors++; $display("FAIL beat_count: got %0d beats expected %0d (left %0d)", got, nbeats, sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (rd_rdy !== 1'b0 || wr_rdy !== 1'b0 || ret_valid !== 1'b0 || ret_last !== 1'b0 || ret_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: rd_rdy=%b wr_rdy=%b valid=%b last=%b data=%h expected all 0",
                     rd_rdy, wr_rdy, ret_valid, ret_last, ret_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1) begin
            errors++; $display("FAIL idle_ready: rd_rdy=%b wr_rdy=%b expected 1 1", rd_rdy, wr_rdy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_word_rw();
        int w;
        do_write(32'h1C00_0010, 3'b010, 4'b1111, 128'hDEAD_BEEF, 1'b0);
        issue_read(32'h1C00_0010, 3'b010, w);
        checks++;
        if (w != 0) begin
            errors++; $display("FAIL wr_recover: read waited %0d cycles expected 0", w);
        end
        collect(1, 0);
    endtask

    task automatic test_byte_write();
        int w;
        do_write(32'h1C00_0010, 3'b000, 4'b0010, 128'h0000_AB00, 1'b0);
        issue_read(32'h1C00_0010, 3'b000, w);
        collect(1, 0);
        do_write(32'h1C00_0010, 3'b010, 4'b0000, 128'hFFFF_FFFF, 1'b0);
        issue_read(32'h1C00_0010, 3'b010, w);
        collect(1, 0);
    endtask

    task automatic test_line_rw();
        int w;
        do_write(32'h0000_0020, 3'b100, 4'b0000,
                 128'h44444444_33333333_22222222_11111111, 1'b0);
        issue_read(32'h0000_002C, 3'b100, w);
        collect(4, 0);
    endtask

    task automatic test_back_to_back();
        int w;
        do_write(32'h0000_0104, 3'b010, 4'b1111, 128'hCAFE_F00D, 1'b1);
        issue_read(32'h0000_0104, 3'b010, w);
        checks++;
        if (w != 0) begin
            errors++; $display("FAIL pending_read: accepted after %0d extra cycles expected 0", w);
        end
        collect(1, 0);
    endtask

    task automatic test_reset_mid_read();
        int w;
        logic [32:0] e;
        issue_read(32'h0000_0020, 3'b100, w);
        rd_req = 1'b0;
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (ret_valid !== 1'b1 || ret_data !== e[31:0]) begin
                errors++; $display("FAIL pre_reset_beat: valid=%b data=%h expected 1 %h", ret_valid, ret_data, e[31:0]);
            end
        end
        @(posedge clk); #2;
        checks++;
        if (ret_valid !== 1'b1) begin
            errors++; $display("FAIL third_beat: valid=%b expected 1", ret_valid);
        end
        rst = 1'b1;
        wr_req = 1'b1;
        #1;
        checks++;
        if (ret_valid !== 1'b0 || ret_last !== 1'b0 || ret_data !== 32'h0) begin
            errors++; $display("FAIL async_reset: valid=%b last=%b data=%h expected 0 0 0", ret_valid, ret_last, ret_data);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (rd_rdy !== 1'b0 || wr_rdy !== 1'b0) begin
                errors++; $display("FAIL rdy_in_reset: rd_rdy=%b wr_rdy=%b expected 0 0", rd_rdy, wr_rdy);
            end
        end
        wr_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        checks++;
        if (rd_rdy !== 1'b1) begin
            errors++; $display("FAIL post_reset_rdy: rd_rdy=%b expected 1", rd_rdy);
        end
        @(posedge clk); #1;
        collect(0, 0);
        issue_read(32'h0000_0020, 3'b100, w);
        collect(4, 0);
    endtask

    task automatic test_hold_and_alias();
        int w;
        do_write(32'h0000_4010, 3'b010, 4'b1111, 128'h600D_F00D, 1'b0);
        issue_read(32'h0000_0010, 3'b010, w);
        collect(1, 2);
        issue_read(32'h1C00_0010, 3'b111, w);
        collect(1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_rw();
        test_byte_write();
        test_line_rw();
        test_back_to_back();
        test_reset_mid_read();
        test_hold_and_alias();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
